// File: rtl/seq_detect_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_detect_param: parametrised serial pattern detector with match counter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seq_detect_param #(
    parameter int                 SEQ_LEN = 5,
    parameter logic [SEQ_LEN-1:0] PATTERN = 5'b11010,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MOORE   = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             d_in,
    output logic             q_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int             KW     = (SEQ_LEN < 2) ? 1 : $clog2(SEQ_LEN);
    localparam logic [KW-1:0]  K_LAST = KW'(SEQ_LEN - 1);

    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
        $error("seq_detect_param: SEQ_LEN must be in 2..16");
    end

    // Longest proper pattern prefix that is a suffix of (first k pattern bits + b).
    function automatic int f_next(input int k, input logic b);
        int                 best;
        int                 pos;
        logic               ok;
        logic               sb;
        logic               pb;
        logic [SEQ_LEN-1:0] t;
        best = 0;
        for (int j = 1; j < SEQ_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int m = 0; m < j; m++) begin
                    pos = k + 1 - j + m;
                    t   = PATTERN >> (SEQ_LEN - 1 - pos);
                    sb  = (pos == k) ? b : t[0];
                    t   = PATTERN >> (SEQ_LEN - 1 - m);
                    pb  = t[0];
                    if (sb != pb) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    logic [KW-1:0]    fb_tab [SEQ_LEN][2];
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit;

    for (genvar gk = 0; gk < SEQ_LEN; gk++) begin : g_k
        for (genvar gb = 0; gb < 2; gb++) begin : g_b
            localparam int NXT = f_next(gk, gb == 1);
            assign fb_tab[gk][gb] = KW'(NXT);
        end
    end

    assign hit = en && !clear && (k == K_LAST) && (d_in == PATTERN[0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k         <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            k         <= k_nxt;
            match_cnt <= cnt_nxt;
            cnt_sat   <= &cnt_nxt;
        end
    end

    always_comb begin
        k_nxt   = k;
        cnt_nxt = match_cnt;
        if (clear) begin
            k_nxt   = '0;
            cnt_nxt = '0;
        end else if (en) begin
            if (hit && !OVERLAP) k_nxt = '0;
            else                 k_nxt = fb_tab[k][d_in];
            if (hit && !cnt_sat) cnt_nxt = match_cnt + CNT_W'(1);
        end
    end

    if (MOORE) begin : g_moore
        logic q_reg;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) q_reg <= 1'b0;
            else          q_reg <= hit;
        end
        assign q_out = q_reg;
    end else begin : g_mealy
        assign q_out = hit;
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// tb_seq_detect_param: five detector configurations driven by a shared stream,
// checked against a sliding-window reference model.
module tb_seq_detect_param;

    localparam int NI = 5;
    // 0: defaults Mealy, 1: 1010 overlap, 2: 1010 no overlap, 3: Moore, 4: 2-bit counter
    localparam int LEN [NI] = '{5, 4, 4, 5, 5};
    localparam int PAT [NI] = '{26, 10, 10, 26, 26};
    localparam int OVL [NI] = '{1, 1, 0, 1, 1};
    localparam int MOO [NI] = '{0, 0, 0, 1, 0};
    localparam int CWD [NI] = '{8, 8, 8, 8, 2};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          clear = 1'b0;
    logic          d_in = 1'b0;
    logic [NI-1:0] q;
    logic [NI-1:0] sat;
    logic [7:0]    cnt [NI];
    logic [1:0]    cnt4;
    int            n_cmp = 0;
    int            n_bad = 0;

    int            win  [NI];
    int            nv   [NI];
    int            mcnt [NI];
    logic          mq   [NI];

    always #5 clk = ~clk;

    seq_detect_param u0 (.clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .d_in(d_in),
                         .q_out(q[0]), .match_cnt(cnt[0]), .cnt_sat(sat[0]));
    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .d_in(d_in),
        .q_out(q[1]), .match_cnt(cnt[1]), .cnt_sat(sat[1]));
    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u2 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .d_in(d_in),
        .q_out(q[2]), .match_cnt(cnt[2]), .cnt_sat(sat[2]));
    seq_detect_param #(.MOORE(1'b1)) u3 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .d_in(d_in),
        .q_out(q[3]), .match_cnt(cnt[3]), .cnt_sat(sat[3]));
    seq_detect_param #(.CNT_W(2)) u4 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .d_in(d_in),
        .q_out(q[4]), .match_cnt(cnt4), .cnt_sat(sat[4]));
    assign cnt[4] = {6'd0, cnt4};

    // A detection is: the last LEN-1 accepted bits since restart, followed by d_in, equal the pattern.
    function automatic logic m_hit(input int i);
        int mask;
        mask = (1 << LEN[i]) - 1;
        return en && !clear && (nv[i] >= LEN[i] - 1) &&
               ((((win[i] << 1) | {31'd0, d_in}) & mask) == PAT[i]);
    endfunction

    function automatic logic exp_q(input int i);
        return (MOO[i] != 0) ? mq[i] : m_hit(i);
    endfunction

    function automatic logic exp_sat(input int i);
        return mcnt[i] == (1 << CWD[i]) - 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NI; i++) begin
                win[i] <= 0; nv[i] <= 0; mcnt[i] <= 0; mq[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (clear) begin
                    win[i] <= 0; nv[i] <= 0; mcnt[i] <= 0; mq[i] <= 1'b0;
                end else if (en) begin
                    mq[i] <= m_hit(i);
                    if (m_hit(i) && mcnt[i] < (1 << CWD[i]) - 1) mcnt[i] <= mcnt[i] + 1;
                    if (m_hit(i) && OVL[i] == 0) begin
                        win[i] <= 0; nv[i] <= 0;
                    end else begin
                        win[i] <= ((win[i] << 1) | {31'd0, d_in}) & 32'hFFFF;
                        nv[i]  <= (nv[i] < 16) ? nv[i] + 1 : 16;
                    end
                end else begin
                    mq[i] <= 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic e, input logic c, input logic d);
        @(negedge clk);
        en = e; clear = c; d_in = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (q[i] !== 1'b0 || cnt[i] !== 8'd0 || sat[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset inst%0d: got q=%b cnt=%0d sat=%b want 0/0/0", i, q[i], cnt[i], sat[i]);
            end
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    // Directed stream: bits/ens/clrs are MSB-first, n bits long.
    task automatic test_stream(input string name, input logic [31:0] bits, input logic [31:0] ens,
                               input logic [31:0] clrs, input int n);
        for (int b = 0; b < n; b++) begin
            drive(ens[n-1-b], clrs[n-1-b], bits[n-1-b]);
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (q[i] !== exp_q(i)) begin
                    n_bad++;
                    $display("FAIL %s q_out inst%0d bit%0d: got %b want %b", name, i, b + 1, q[i], exp_q(i));
                end
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (cnt[i] !== 8'(mcnt[i]) || sat[i] !== exp_sat(i)) begin
                    n_bad++;
                    $display("FAIL %s count inst%0d bit%0d: got cnt=%0d sat=%b want cnt=%0d sat=%b",
                             name, i, b + 1, cnt[i], sat[i], mcnt[i], exp_sat(i));
                end
            end
        end
    endtask

    task automatic test_mealy_basic();
        test_stream("restart", 32'b0, 32'b1, 32'b1, 1);
        test_stream("basic", 32'b11010, 32'b11111, 32'b0, 5);
        n_cmp++;
        if (cnt[0] !== 8'd1) begin
            n_bad++; $display("FAIL basic_cnt: got %0d want 1", cnt[0]);
        end
        test_stream("restart", 32'b0, 32'b1, 32'b1, 1);
        test_stream("fallback", 32'b11011010, 32'hFF, 32'b0, 8);
        n_cmp++;
        if (cnt[0] !== 8'd1) begin
            n_bad++; $display("FAIL fallback_cnt: got %0d want 1", cnt[0]);
        end
    endtask

    task automatic test_overlap();
        test_stream("restart", 32'b0, 32'b1, 32'b1, 1);
        test_stream("overlap", 32'b1010101, 32'h7F, 32'b0, 7);
        n_cmp++;
        if (cnt[1] !== 8'd2 || cnt[2] !== 8'd1) begin
            n_bad++; $display("FAIL overlap_cnt: got %0d/%0d want 2/1", cnt[1], cnt[2]);
        end
    endtask

    task automatic test_en_gap();
        test_stream("restart", 32'b0, 32'b1, 32'b1, 1);
        test_stream("en_gap", 32'b11010110, 32'b11100011, 32'b0, 8);
        n_cmp++;
        if (cnt[3] !== 8'd1) begin
            n_bad++; $display("FAIL en_gap_cnt: got %0d want 1", cnt[3]);
        end
    endtask

    task automatic test_saturation_clear();
        logic [31:0] five_matches;
        test_stream("restart", 32'b0, 32'b1, 32'b1, 1);
        five_matches = 32'b1101011010110101101011010;
        test_stream("saturate", five_matches, 32'h1FFFFFF, 32'b0, 25);
        n_cmp++;
        if (cnt[4] !== 8'd3 || sat[4] !== 1'b1) begin
            n_bad++; $display("FAIL sat_cnt: got cnt=%0d sat=%b want 3/1", cnt[4], sat[4]);
        end
        test_stream("clear_final", 32'b11010, 32'b11111, 32'b00001, 5);
        n_cmp++;
        if (cnt[4] !== 8'd0 || sat[4] !== 1'b0 || cnt[0] !== 8'd0) begin
            n_bad++; $display("FAIL clear_cnt: got cnt=%0d sat=%b want 0/0", cnt[4], sat[4]);
        end
    endtask

    task automatic test_reset_mid();
        test_stream("pre_reset", 32'b1101, 32'hF, 32'b0, 4);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (q[i] !== 1'b0 || cnt[i] !== 8'd0 || sat[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset inst%0d: got q=%b cnt=%0d sat=%b want 0/0/0", i, q[i], cnt[i], sat[i]);
            end
        end
        #1 reset_n = 1'b1;
        test_stream("post_reset", 32'b011010, 32'h3F, 32'b0, 6);
        n_cmp++;
        if (cnt[0] !== 8'd1) begin
            n_bad++; $display("FAIL post_reset_cnt: got %0d want 1", cnt[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] b, e, c;
        for (int blk = 0; blk < 16; blk++) begin
            b = $urandom;
            e = 32'd0;
            c = 32'd0;
            for (int j = 0; j < 32; j++) begin
                e[j] = ($urandom_range(0, 9) < 8);
                c[j] = ($urandom_range(0, 39) == 0);
            end
            test_stream("random", b, e, c, 32);
        end
    endtask

    initial begin
        test_reset();
        test_mealy_basic();
        test_overlap();
        test_en_gap();
        test_saturation_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
